// File: rtl/latch_write_sequencer.sv
// rtl/latch_write_sequencer.sv - round-robin write sequencer for a shared bank of gated D latches
// Drives one latch at a time through setup, C-pulse and hold so D is stable around every C window.
module latch_write_sequencer #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_LATCH    = 4,
  parameter int ADDR_W       = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           ack,
  output logic [DATA_WIDTH-1:0]        latch_d,
  output logic [NUM_LATCH-1:0]         latch_c,
  output logic [2:0]                   grant_id,
  output logic                         busy
);

  localparam int MAX_PH = (SETUP_CYCLES > PULSE_CYCLES)
                        ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                        : ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
  localparam int CNT_W = (MAX_PH < 2) ? 1 : $clog2(MAX_PH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] PULSE = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [2:0]            grant_q, grant_d;
  logic [2:0]            rr_q, rr_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [NUM_LATCH-1:0]  c_q, c_d;
  logic                  busy_q, busy_d;

  logic                  found;
  logic [2:0]            win;
  int                    idx;

  // Rotating priority: first requester at or after rr_q, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = SETUP;
        cnt_d   = '0;
        addr_d  = req_addr[int'(win)*ADDR_W +: ADDR_W];
        data_d  = req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
        grant_d = win;
        rr_d    = (int'(win) == NUM_REQ - 1) ? 3'd0 : win + 3'd1;
      end
      SETUP: if (cnt_q == SETUP_LAST) begin
        state_d = PULSE;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_W'(1);
      PULSE: if (cnt_q == PULSE_LAST) begin
        state_d = HOLD;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_W'(1);
      default: if (cnt_q == HOLD_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_W'(1);
    endcase
    // Outputs are computed from the next state so they are registered yet phase-aligned.
    c_d    = (state_d == PULSE) ? (NUM_LATCH'(1) << addr_d) : '0;
    ack_d  = (state_d == HOLD && cnt_d == HOLD_LAST) ? (NUM_REQ'(1) << grant_d) : '0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      ack_q   <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      ack_q   <= ack_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign latch_d  = data_q;
  assign latch_c  = c_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_latch_write_sequencer.sv
// tb/tb_latch_write_sequencer.sv - scoreboard bench for latch_write_sequencer, default and 2/3/2 timing
module tb_latch_write_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack0, ack1, lc0, lc1;
  logic [7:0]  d0, d1;
  logic [2:0]  g0, g1;
  logic        b0, b1;

  always #5 clock = ~clock;

  latch_write_sequencer dut0 (
    .clock(clock), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack0), .latch_d(d0), .latch_c(lc0), .grant_id(g0), .busy(b0));

  latch_write_sequencer #(.SETUP_CYCLES(2), .PULSE_CYCLES(3), .HOLD_CYCLES(2)) dut1 (
    .clock(clock), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack1), .latch_d(d1), .latch_c(lc1), .grant_id(g1), .busy(b1));

  typedef struct {
    int id; int addr; int data; int g; int cs; int ce; int ak;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   s_c[2] = '{1, 2};
  int   p_c[2] = '{2, 3};
  int   h_c[2] = '{1, 2};
  int   rr[2]  = '{0, 0};
  int   nf[2]  = '{0, 0};
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   run = 1'b0;

  task automatic cmp(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference: a write granted at edge e occupies the bank for S+P+H cycles, then one idle cycle.
  task automatic model_step(int c);
    int w;
    exp_t t;
    w = -1;
    if (cyc >= nf[c] && req != 4'd0) begin
      for (int k = 0; k < 4; k++)
        if (w < 0 && req[(rr[c] + k) % 4]) w = (rr[c] + k) % 4;
      t.id   = w;
      t.addr = int'(req_addr[w*2 +: 2]);
      t.data = int'(req_data[w*8 +: 8]);
      t.g    = cyc;
      t.cs   = cyc + s_c[c];
      t.ce   = cyc + s_c[c] + p_c[c] - 1;
      t.ak   = cyc + s_c[c] + p_c[c] + h_c[c] - 1;
      if (c == 0) q0.push_back(t); else q1.push_back(t);
      rr[c] = (w + 1) % 4;
      nf[c] = t.ak + 2;
    end
  endtask

  task automatic check(int c, logic [3:0] a, logic [7:0] d, logic [3:0] lc, logic [2:0] g, logic b);
    exp_t h;
    bit   hv;
    bit   act;
    hv = 1'b0;
    if (c == 0 && q0.size() > 0) begin hv = 1'b1; h = q0[0]; end
    if (c == 1 && q1.size() > 0) begin hv = 1'b1; h = q1[0]; end
    act = hv && (cyc <= h.ak);
    cmp($sformatf("cfg%0d_latch_c", c), int'(lc), (hv && cyc >= h.cs && cyc <= h.ce) ? (1 << h.addr) : 0);
    cmp($sformatf("cfg%0d_ack", c), int'(a), (hv && cyc == h.ak) ? (1 << h.id) : 0);
    cmp($sformatf("cfg%0d_busy", c), int'(b), int'(act));
    if (act) begin
      cmp($sformatf("cfg%0d_latch_d", c), int'(d), h.data);
      cmp($sformatf("cfg%0d_grant_id", c), int'(g), h.id);
    end
    if (hv && cyc == h.ak) begin
      if (c == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
  endtask

  always @(negedge clock) begin
    if (run && !reset) begin
      check(0, ack0, d0, lc0, g0, b0);
      check(1, ack1, d1, lc1, g1, b1);
    end
  end

  task automatic tick();
    @(posedge clock);
    cyc++;
    if (!reset) begin
      model_step(0);
      model_step(1);
    end
    #1;
  endtask

  // Requesters hold req until their own ack from the default-timing instance.
  task automatic handshake(string nm, int budget);
    int n;
    n = 0;
    while ((req != 4'd0 || b0 || b1) && n < budget) begin
      tick();
      req = req & ~ack0;
      n++;
    end
    cmp({nm, "_done"}, int'(req != 4'd0 || b0 || b1), 0);
  endtask

  initial begin
    tick();
    tick();
    cmp("rst_ack", int'(ack0), 0);
    cmp("rst_latch_c", int'(lc0), 0);
    cmp("rst_latch_d", int'(d0), 0);
    cmp("rst_grant_id", int'(g0), 0);
    cmp("rst_busy", int'(b0), 0);
    reset = 1'b0;
    run = 1'b1;

    req = 4'b0001; req_addr = 8'h02; req_data = 32'h0000_00A5;
    handshake("single", 40);

    req = 4'hF; req_addr = 8'($urandom); req_data = $urandom;
    handshake("all_four", 80);

    req = 4'b0001; req_data = 32'h0000_0011; req_addr = 8'h01;
    for (int n = 0; n < 10 && lc0 == 4'd0; n++) tick();
    cmp("dchg_in_pulse", int'(lc0), 4'b0010);
    req_data[7:0] = 8'hFF;
    req = 4'b0000;
    for (int n = 0; n < 12; n++) tick();

    for (int n = 0; n < 300; n++) begin
      tick();
      req      = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      req_addr = 8'($urandom);
      req_data = $urandom;
    end
    req = 4'd0;
    for (int n = 0; n < 12; n++) tick();

    req = 4'b0010; req_addr = 8'h0C; req_data = 32'h0000_3C00;
    for (int n = 0; n < 10 && lc0 == 4'd0; n++) tick();
    cmp("pre_reset_pulse", int'(lc0), 4'b1000);
    #2 reset = 1'b1;
    #1;
    cmp("async_rst_latch_c0", int'(lc0), 0);
    cmp("async_rst_latch_c1", int'(lc1), 0);
    cmp("async_rst_ack", int'(ack0), 0);
    cmp("async_rst_busy", int'(b0), 0);
    q0.delete(); q1.delete();
    rr = '{0, 0}; nf = '{0, 0};
    tick();
    cmp("in_rst_ack", int'(ack0 | ack1), 0);
    reset = 1'b0;
    handshake("after_reset", 40);

    for (int n = 0; n < 200; n++) begin
      tick();
      req      = 4'($urandom_range(0, 15));
      req_addr = 8'($urandom);
      req_data = $urandom;
    end
    req = 4'd0;
    for (int n = 0; n < 15; n++) tick();
    cmp("drained_q0", q0.size(), 0);
    cmp("drained_q1", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
